// File: rtl/tpm_tis_responder_if.sv
// Host-side TPM TIS bus between the TPMManager initiator and a responder.
// master: drives the address, write data, direction and start request.
// slave : returns ready, read data and the response-valid pulse.
interface tpm_tis_responder_if;
  logic [15:0] hostAddr;
  logic [7:0]  hostInData;
  logic        hostIsWrite;
  logic        hostStart;
  logic        hostIsReady;
  logic [7:0]  hostOutData;
  logic        hostGotResponse;

  modport master (
    output hostAddr, hostInData, hostIsWrite, hostStart,
    input  hostIsReady, hostOutData, hostGotResponse
  );

  modport slave (
    input  hostAddr, hostInData, hostIsWrite, hostStart,
    output hostIsReady, hostOutData, hostGotResponse
  );
endinterface

// File: rtl/tpm_tis_responder.sv
// TPM TIS FIFO-interface endpoint that stands in for a physical TPM. It serves
// ACCESS (0x0000), STS (0x0018) and DATA_FIFO (0x0024), runs the
// IDLE -> RECEPTION -> EXECUTION -> COMPLETION lifecycle and answers every
// command with a canned 10-byte response.
// Ports: clk, reset (synchronous, active-low), bus (host bus, slave side),
//        cmdLength/cmdCode (parsed header), cmdDone (pulse on completion),
//        overflow (sticky, command exceeded the buffer).
module tpm_tis_responder #(
  parameter int unsigned BUSY_CYCLES  = 5,
  parameter int unsigned EXEC_CYCLES  = 30,
  parameter int unsigned MAX_CMD      = 64,
  parameter logic [7:0]  ACCESS_VALUE = 8'hA1
) (
  input  logic                 clk,
  input  logic                 reset,
  tpm_tis_responder_if.slave   bus,
  output logic [31:0]          cmdLength,
  output logic [31:0]          cmdCode,
  output logic                 cmdDone,
  output logic                 overflow
);

  localparam int unsigned BUSY_W   = (BUSY_CYCLES > 0) ? $clog2(BUSY_CYCLES + 1) : 1;
  localparam int unsigned EXEC_W   = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES + 1) : 1;
  localparam int unsigned IDX_W    = (MAX_CMD > 1) ? $clog2(MAX_CMD) : 1;
  localparam int unsigned RESP_LEN = 10;
  localparam logic [15:0] ADDR_ACCESS = 16'h0000;
  localparam logic [15:0] ADDR_STS    = 16'h0018;
  localparam logic [15:0] ADDR_FIFO   = 16'h0024;
  localparam logic [31:0] RC_SIZE     = 32'h0000_0142;

  typedef enum logic [1:0] {
    ST_IDLE, ST_RECEPTION, ST_EXECUTION, ST_COMPLETION
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic [BUSY_W-1:0]   busy_q, busy_d;
  logic                pend_q, pend_d;
  logic [15:0]         pend_addr_q, pend_addr_d;
  logic [7:0]          pend_data_q, pend_data_d;
  logic                pend_wr_q, pend_wr_d;
  logic [7:0]          out_data_q, out_data_d;
  logic                got_resp_q, got_resp_d;
  logic [31:0]         cmd_len_q, cmd_len_d;
  logic [31:0]         cmd_code_q, cmd_code_d;
  logic                cmd_done_q, cmd_done_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         bytes_rx_q, bytes_rx_d;
  logic [EXEC_W-1:0]   exec_cnt_q, exec_cnt_d;
  logic [3:0]          resp_idx_q, resp_idx_d;
  logic [7:0]          buf_q [MAX_CMD];
  logic [7:0]          buf_d [MAX_CMD];

  logic       rx_complete;
  logic       rc_ok;
  logic [7:0] sts_val;
  logic [7:0] resp_byte;

  // Header fully received and no further payload bytes expected.
  assign rx_complete = (bytes_rx_q >= 32'd6) && (bytes_rx_q >= cmd_len_q);
  assign rc_ok = (cmd_len_q >= 32'd10) && (cmd_len_q <= 32'(MAX_CMD)) && !ovf_q;

  // STS read value for the current lifecycle state.
  always_comb begin
    sts_val = 8'hC4;
    case (state_q)
      ST_IDLE:       sts_val = 8'hC4;
      ST_RECEPTION:  sts_val = rx_complete ? 8'h80 : 8'h88;
      ST_EXECUTION:  sts_val = 8'h04;
      ST_COMPLETION: sts_val = (resp_idx_q < 4'(RESP_LEN)) ? 8'h94 : 8'h84;
      default:       sts_val = 8'hC4;
    endcase
  end

  // Canned response: echoed tag, size 10, return code.
  always_comb begin
    resp_byte = 8'h00;
    case (resp_idx_q)
      4'd0:    resp_byte = buf_q[0];
      4'd1:    resp_byte = buf_q[1];
      4'd5:    resp_byte = 8'h0A;
      4'd6:    resp_byte = rc_ok ? 8'h00 : RC_SIZE[31:24];
      4'd7:    resp_byte = rc_ok ? 8'h00 : RC_SIZE[23:16];
      4'd8:    resp_byte = rc_ok ? 8'h00 : RC_SIZE[15:8];
      4'd9:    resp_byte = rc_ok ? 8'h00 : RC_SIZE[7:0];
      default: resp_byte = 8'h00;
    endcase
  end

  // Next-state: execution timer, then the transaction latched one cycle earlier,
  // then the bus handshake.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    pend_wr_d   = pend_wr_q;
    out_data_d  = out_data_q;
    got_resp_d  = 1'b0;
    cmd_len_d   = cmd_len_q;
    cmd_code_d  = cmd_code_q;
    cmd_done_d  = 1'b0;
    ovf_d       = ovf_q;
    bytes_rx_d  = bytes_rx_q;
    exec_cnt_d  = exec_cnt_q;
    resp_idx_d  = resp_idx_q;
    buf_d       = buf_q;

    if (state_q == ST_EXECUTION) begin
      if (exec_cnt_q == EXEC_W'(EXEC_CYCLES - 1)) begin
        state_d    = ST_COMPLETION;
        cmd_done_d = 1'b1;
        resp_idx_d = 4'd0;
      end else begin
        exec_cnt_d = exec_cnt_q + EXEC_W'(1);
      end
    end

    if (pend_q) begin
      pend_d = 1'b0;
      if (!pend_wr_q) begin
        got_resp_d = 1'b1;
        out_data_d = 8'hFF;
        case (pend_addr_q)
          ADDR_ACCESS: out_data_d = ACCESS_VALUE;
          ADDR_STS:    out_data_d = sts_val;
          ADDR_FIFO: begin
            if ((state_q == ST_COMPLETION) && (resp_idx_q < 4'(RESP_LEN))) begin
              out_data_d = resp_byte;
              resp_idx_d = resp_idx_q + 4'd1;
            end
          end
          default: out_data_d = 8'hFF;
        endcase
      end else begin
        case (pend_addr_q)
          ADDR_STS: begin
            // commandReady has priority over go when both bits are set.
            if (pend_data_q[6]) begin
              state_d    = ST_IDLE;
              bytes_rx_d = 32'd0;
              exec_cnt_d = '0;
              resp_idx_d = 4'd0;
              cmd_len_d  = 32'd0;
              cmd_code_d = 32'd0;
              ovf_d      = 1'b0;
              cmd_done_d = 1'b0;
              for (int i = 0; i < int'(MAX_CMD); i++) buf_d[i] = 8'h00;
            end else if (pend_data_q[5] && (state_q == ST_RECEPTION) && rx_complete) begin
              state_d    = ST_EXECUTION;
              exec_cnt_d = '0;
            end
          end
          ADDR_FIFO: begin
            // Bytes beyond the declared size are dropped uncounted; bytes beyond
            // the buffer are counted so the command can still be completed.
            if (((state_q == ST_IDLE) || (state_q == ST_RECEPTION)) && !rx_complete) begin
              if (bytes_rx_q >= 32'(MAX_CMD)) begin
                ovf_d = 1'b1;
              end else begin
                buf_d[bytes_rx_q[IDX_W-1:0]] = pend_data_q;
              end
              if ((bytes_rx_q >= 32'd2) && (bytes_rx_q <= 32'd5)) begin
                cmd_len_d = {cmd_len_q[23:0], pend_data_q};
              end
              if ((bytes_rx_q >= 32'd6) && (bytes_rx_q <= 32'd9)) begin
                cmd_code_d = {cmd_code_q[23:0], pend_data_q};
              end
              bytes_rx_d = bytes_rx_q + 32'd1;
              state_d    = ST_RECEPTION;
            end
          end
          default: ;
        endcase
      end
    end

    // Accept, then hold ready low for BUSY_CYCLES+1 cycles.
    if (ready_q && bus.hostStart) begin
      ready_d     = 1'b0;
      busy_d      = BUSY_W'(BUSY_CYCLES);
      pend_d      = 1'b1;
      pend_addr_d = bus.hostAddr;
      pend_data_d = bus.hostInData;
      pend_wr_d   = bus.hostIsWrite;
    end else if (!ready_q) begin
      if (busy_q == '0) ready_d = 1'b1;
      else              busy_d  = busy_q - BUSY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      busy_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= 16'h0000;
      pend_data_q <= 8'h00;
      pend_wr_q   <= 1'b0;
      out_data_q  <= 8'h00;
      got_resp_q  <= 1'b0;
      cmd_len_q   <= 32'd0;
      cmd_code_q  <= 32'd0;
      cmd_done_q  <= 1'b0;
      ovf_q       <= 1'b0;
      bytes_rx_q  <= 32'd0;
      exec_cnt_q  <= '0;
      resp_idx_q  <= 4'd0;
      for (int i = 0; i < int'(MAX_CMD); i++) buf_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      pend_wr_q   <= pend_wr_d;
      out_data_q  <= out_data_d;
      got_resp_q  <= got_resp_d;
      cmd_len_q   <= cmd_len_d;
      cmd_code_q  <= cmd_code_d;
      cmd_done_q  <= cmd_done_d;
      ovf_q       <= ovf_d;
      bytes_rx_q  <= bytes_rx_d;
      exec_cnt_q  <= exec_cnt_d;
      resp_idx_q  <= resp_idx_d;
      for (int i = 0; i < int'(MAX_CMD); i++) buf_q[i] <= buf_d[i];
    end
  end

  assign bus.hostIsReady     = ready_q;
  assign bus.hostOutData     = out_data_q;
  assign bus.hostGotResponse = got_resp_q;
  assign cmdLength           = cmd_len_q;
  assign cmdCode             = cmd_code_q;
  assign cmdDone             = cmd_done_q;
  assign overflow            = ovf_q;

endmodule

// File: tb/tb_tpm_tis_responder.sv
// Scoreboard bench for tpm_tis_responder: reads push their expected byte and
// due cycle; a negedge monitor pops and compares on every hostGotResponse.
module tb_tpm_tis_responder;
  localparam logic [15:0] A_ACC  = 16'h0000;
  localparam logic [15:0] A_STS  = 16'h0018;
  localparam logic [15:0] A_FIFO = 16'h0024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cmdLength, cmdCode;
  logic        cmdDone, overflow;

  tpm_tis_responder_if bus ();

  tpm_tis_responder #(
    .BUSY_CYCLES(5), .EXEC_CYCLES(30), .MAX_CMD(64), .ACCESS_VALUE(8'hA1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cmdLength(cmdLength), .cmdCode(cmdCode), .cmdDone(cmdDone), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_drv = 0;

  logic [7:0] exp_q [$];
  int         due_q [$];
  string      nm_q  [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (bus.hostGotResponse === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_response", 32'(bus.hostOutData), 32'hFFFF_FFFF);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        automatic int d = due_q.pop_front();
        automatic string n = nm_q.pop_front();
        chk(n, 32'(bus.hostOutData), 32'(e));
        chk({n, "_latency"}, 32'(cyc), 32'(d));
      end
    end
    if (cmdDone === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // One bus transaction from a negedge; returns at the negedge where ready is back.
  task automatic txn(input logic [15:0] a, input logic [7:0] d, input logic w,
                     input logic [7:0] e, input string nm);
    int n = 0;
    int lowc = 0;
    while (bus.hostIsReady !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (bus.hostIsReady !== 1'b1) begin
      chk("ready_timeout", 32'(bus.hostIsReady), 32'd1);
      return;
    end
    bus.hostAddr = a; bus.hostInData = d; bus.hostIsWrite = w; bus.hostStart = 1'b1;
    last_drv = cyc;
    if (!w) begin
      exp_q.push_back(e);
      due_q.push_back(cyc + 2);
      nm_q.push_back(nm);
    end
    @(posedge clk); #1;
    bus.hostStart = 1'b0;
    @(negedge clk);
    while (bus.hostIsReady !== 1'b1 && lowc < 50) begin lowc++; @(negedge clk); end
    chk("ready_low_cycles", 32'(lowc), 32'd6);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e, input string nm);
    txn(a, 8'h00, 1'b0, e, nm);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    txn(a, d, 1'b1, 8'h00, "");
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 300) begin @(negedge clk); n++; end
    chk("cmd_done_seen", 32'(done_cnt), 32'(prev + 1));
  endtask

  logic [7:0] cmd1     [12] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C,
                                8'h00, 8'h00, 8'h01, 8'h7B, 8'h00, 8'h00};
  logic [7:0] cmd8     [8]  = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00};
  logic [7:0] hdr70    [10] = '{8'h80, 8'h02, 8'h00, 8'h00, 8'h00, 8'h46,
                                8'h00, 8'h00, 8'h01, 8'h7B};
  logic [7:0] resp_ok  [10] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A,
                                8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] resp_bad [10] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A,
                                8'h00, 8'h00, 8'h01, 8'h42};
  logic [7:0] resp_70  [10] = '{8'h80, 8'h02, 8'h00, 8'h00, 8'h00, 8'h0A,
                                8'h00, 8'h00, 8'h01, 8'h42};

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int go_cyc;
    int prev;
    bus.hostAddr = 16'h0; bus.hostInData = 8'h0; bus.hostIsWrite = 1'b0; bus.hostStart = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",   32'(bus.hostIsReady), 32'd1);
    chk("rst_got",     32'(bus.hostGotResponse), 32'd0);
    chk("rst_outdata", 32'(bus.hostOutData), 32'd0);
    chk("rst_len",     cmdLength, 32'd0);
    chk("rst_code",    cmdCode, 32'd0);
    chk("rst_done",    32'(cmdDone), 32'd0);
    chk("rst_ovf",     32'(overflow), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Register map basics.
    rd(A_ACC, 8'hA1, "access_rd");
    wr(A_ACC, 8'h55);
    rd(A_ACC, 8'hA1, "access_ro");
    rd(16'h0004, 8'hFF, "unmapped_rd");
    rd(A_FIFO, 8'hFF, "fifo_rd_idle");
    rd(A_STS, 8'hC4, "sts_idle");

    // Well-formed 12-byte command through the full lifecycle.
    wr(A_STS, 8'h40);
    foreach (cmd1[i]) wr(A_FIFO, cmd1[i]);
    rd(A_STS, 8'h80, "sts_rx_done");
    prev = done_cnt;
    wr(A_STS, 8'h20);
    go_cyc = last_drv;
    repeat (4) rd(A_STS, 8'h04, "sts_exec");
    rd(A_STS, 8'h94, "sts_cmpl");
    chk("done_once", 32'(done_cnt), 32'(prev + 1));
    chk("exec_latency", 32'(done_cyc - go_cyc), 32'd32);
    chk("cmd_length", cmdLength, 32'h0000_000C);
    chk("cmd_code", cmdCode, 32'h0000_017B);
    foreach (resp_ok[i]) rd(A_FIFO, resp_ok[i], "resp_ok");
    rd(A_STS, 8'h84, "sts_drained");
    rd(A_FIFO, 8'hFF, "fifo_after_drain");
    rd(A_STS, 8'h84, "sts_stays_cmpl");
    wr(A_STS, 8'h40);
    rd(A_STS, 8'hC4, "sts_abort_idle");
    chk("len_cleared", cmdLength, 32'd0);

    // Undersized command: size field 8.
    foreach (cmd8[i]) wr(A_FIFO, cmd8[i]);
    rd(A_STS, 8'h80, "sts_rx8_done");
    prev = done_cnt;
    wr(A_STS, 8'h60);
    rd(A_STS, 8'h88 ^ 8'h4C, "sts_both_bits_idle");
    foreach (cmd8[i]) wr(A_FIFO, cmd8[i]);
    wr(A_STS, 8'h20);
    wait_done(prev);
    chk("len8", cmdLength, 32'd8);
    foreach (resp_bad[i]) rd(A_FIFO, resp_bad[i], "resp_small");
    wr(A_STS, 8'h40);

    // 70-byte command into a 64-byte buffer.
    for (int i = 0; i < 70; i++) wr(A_FIFO, (i < 10) ? hdr70[i] : 8'(i));
    chk("overflow_set", 32'(overflow), 32'd1);
    rd(A_STS, 8'h80, "sts_rx70_done");
    prev = done_cnt;
    wr(A_STS, 8'h20);
    wait_done(prev);
    foreach (resp_70[i]) rd(A_FIFO, resp_70[i], "resp_ovf");
    wr(A_STS, 8'h40);
    chk("overflow_cleared", 32'(overflow), 32'd0);

    // Go mid-reception is ignored; abort mid-execution suppresses cmdDone.
    for (int i = 0; i < 7; i++) wr(A_FIFO, cmd1[i]);
    wr(A_STS, 8'h20);
    rd(A_STS, 8'h88, "sts_go_ignored");
    for (int i = 7; i < 12; i++) wr(A_FIFO, cmd1[i]);
    wr(A_FIFO, 8'hEE);
    rd(A_STS, 8'h80, "sts_extra_dropped");
    prev = done_cnt;
    wr(A_STS, 8'h20);
    rd(A_STS, 8'h04, "sts_exec_before_abort");
    wr(A_STS, 8'h40);
    repeat (40) @(negedge clk);
    chk("no_done_after_abort", 32'(done_cnt), 32'(prev));
    rd(A_STS, 8'hC4, "sts_idle_after_abort");

    // Reset in the middle of a read: no response pulse, outputs back to reset.
    for (int i = 0; i < 6; i++) wr(A_FIFO, cmd1[i]);
    chk("len_before_reset", cmdLength, 32'h0000_000C);
    bus.hostAddr = A_ACC; bus.hostIsWrite = 1'b0; bus.hostStart = 1'b1;
    @(posedge clk); #1;
    bus.hostStart = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rr_ready",   32'(bus.hostIsReady), 32'd1);
    chk("rr_got",     32'(bus.hostGotResponse), 32'd0);
    chk("rr_outdata", 32'(bus.hostOutData), 32'd0);
    chk("rr_len",     cmdLength, 32'd0);
    chk("rr_code",    cmdCode, 32'd0);
    chk("rr_ovf",     32'(overflow), 32'd0);
    repeat (3) @(negedge clk);
    rd(A_STS, 8'hC4, "sts_after_reset");

    repeat (5) @(negedge clk);
    chk("resp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tpm_tis_responder.md
Name: tpm_tis_responder

Overview:
- Synthesizable TPM TIS FIFO-interface endpoint that answers the TPMManager host-side bus (hostAddr/hostStart/hostIsReady/hostGotResponse).
- It sits at the far end of that bus. It stands in for a physical TPM during bring-up and loopback, so the manager's initiator FSM can run on hardware without a TPM attached.
- It implements the ACCESS, STS and DATA_FIFO registers and the TIS command lifecycle: IDLE -> RECEPTION -> EXECUTION -> COMPLETION.
- For every command it returns a canned 10-byte TPM response.

Parameters:
- BUSY_CYCLES, 5: extra cycles hostIsReady stays low after an accepted transaction.
- EXEC_CYCLES, 30: clocks spent in EXECUTION before COMPLETION.
- MAX_CMD, 64: command buffer depth in bytes (power of two).
- ACCESS_VALUE, 8'hA1: value returned on reads of address 16'h0000.

Ports:
- clk in 1: single clock; all logic on posedge.
- reset in 1: synchronous, active-low; reset==0 at a posedge resets the block.
- hostAddr in 16: register address, sampled on accept.
- hostInData in 8: write data, sampled on accept.
- hostIsWrite in 1: 1 = write, 0 = read, sampled on accept.
- hostStart in 1: transaction request.
- hostIsReady out 1: responder can accept.
- hostOutData out 8: read data; held until the next read completes.
- hostGotResponse out 1: one-cycle pulse, hostOutData valid.
- cmdLength out 32: big-endian size field from command bytes 2..5.
- cmdCode out 32: command bytes 6..9.
- cmdDone out 1: one-cycle pulse on entry to COMPLETION.
- overflow out 1: sticky; set when a FIFO write arrives with the buffer full; cleared by abort or reset.

Behaviour:
- Reset values: hostIsReady=1, hostOutData=0, hostGotResponse=0, cmdLength=0, cmdCode=0, cmdDone=0, overflow=0, state=IDLE, all counters 0.
- Reset wins over any in-flight transaction; no hostGotResponse pulse is emitted after reset.
- Accept condition: hostStart && hostIsReady at posedge N.
  - hostIsReady=0 from N+1 for exactly BUSY_CYCLES+1 cycles, then returns to 1.
  - hostStart while not ready is ignored.
- Reads: hostOutData is updated and hostGotResponse=1 during cycle N+2 only. Writes produce no pulse.
- Address 16'h0000 (ACCESS):
  - Read returns ACCESS_VALUE.
  - Writes are ignored.
- Address 16'h0018 (STS), read values by state:
  - IDLE: 8'hC4.
  - RECEPTION with bytesRx < cmdLength, or fewer than 6 bytes received: 8'h88.
  - RECEPTION with all bytes received: 8'h80.
  - EXECUTION: 8'h04.
  - COMPLETION with bytes remaining: 8'h94.
  - COMPLETION with response drained: 8'h84.
- Address 16'h0018 (STS), writes:
  - 8'h40 (commandReady) from any state: abort to IDLE; clears buffer, counters, cmdLength, cmdCode and overflow.
  - 8'h20 (go) in RECEPTION with all bytes received: enter EXECUTION.
  - Go in any other state is ignored.
  - When bits 6 and 5 are both set, commandReady wins.
- Address 16'h0024 (DATA_FIFO), writes:
  - In IDLE: byte 0 is stored and the state moves to RECEPTION.
  - In RECEPTION: bytes are stored at index bytesRx.
  - bytesRx is a 32-bit counter.
  - Bytes at indices 2..5 load cmdLength MSB-first; bytes 6..9 load cmdCode.
  - Bytes past cmdLength (once bytesRx>=6) are dropped and not counted.
  - Writes at index >= MAX_CMD are dropped and set overflow.
  - Writes in EXECUTION and COMPLETION are ignored.
- Address 16'h0024 (DATA_FIFO), reads:
  - In COMPLETION: pop the next response byte.
  - Reads after the response is drained, and reads outside COMPLETION, return 8'hFF without state change.
- EXECUTION: a free-running clk counter starts at 0 on entry. After EXEC_CYCLES clocks the state moves to COMPLETION and cmdDone pulses on that transition cycle.
- Response, 10 bytes:
  - Bytes 0..1: tag echoed from command bytes 0..1.
  - Bytes 2..5: 32'h0000000A.
  - Bytes 6..9: return code.
  - Return code is 32'h00000000 if 10 <= cmdLength <= MAX_CMD and overflow==0; otherwise 32'h00000142 (TPM_RC_COMMAND_SIZE).
- Unmapped addresses: reads return 8'hFF; writes are ignored.
- Leaving COMPLETION requires a commandReady write; draining the response alone does not return to IDLE.
- A second command is accepted only after returning to IDLE; each command is independent of the previous one.

Test Plan:
- Reset then read ACCESS -> hostGotResponse at accept+2 with 8'hA1. hostIsReady low for 6 cycles after each accept.
- Write STS 40, write FIFO bytes 80 01 00 00 00 0C 00 00 01 7B 00 00, read STS -> 80. Then write STS 20, poll STS -> 04 repeatedly, then 94 after 30 clks, with cmdDone pulse, cmdLength=0x0C, cmdCode=0x0000017B.
- Read FIFO 10x after completion -> 80 01 00 00 00 0A 00 00 00 00. STS -> 84. Extra FIFO read -> FF. Write STS 40 -> STS reads C4.
- Command with size field 8 (8 bytes), go -> response return code 00 00 01 42. Command of 70 bytes with MAX_CMD=64 -> overflow=1, return code 0x142.
- Go issued mid-RECEPTION (after 7 of 12 bytes) -> ignored, STS still 88. Abort (STS 40) mid-EXECUTION -> IDLE, cmdDone never pulses.
- Assert reset during a read, between accept and accept+2 -> no hostGotResponse pulse. All outputs at reset values the next cycle; hostIsReady=1.
